sat_pla_solver: RTL and testbench
=================================

// Module: sat_pla_solver
// PURPOSE
// - Hardware 3SAT search engine: a programmable two-level array evaluates a CNF formula over N
//   variables (per-clause OR of literals, AND of all clauses) on a registered assignment.
// - While unsatisfied, flips one variable of the first failing clause each cycle, chosen by an LFSR
//   (WalkSAT style). Restarts from a random assignment every FLIPS cycles.
// - Top of the solver datapath; clause masks are supplied by the host.
// PARAMETERS
// - N      3  number of variables, 2..32.
// - M      4  number of clauses, >=1.
// - FLIPS  8  flips per try before random restart, >=2.
// PORTS
// - clk        in   1    single clock, rising edge.
// - reset      in   1    asynchronous, active-high.
// - pos_mask   in   M*N  bits [m*N+:N]: variables appearing uninverted in clause m.
// - neg_mask   in   M*N  bits [m*N+:N]: variables appearing inverted in clause m.
// - values     out  N    current assignment register.
// - flip_mask  out  N    one-hot variable flipped at the next edge; 0 when none.
// - out        out  1    formula satisfied by values (combinational).
// BEHAVIOUR
// - clause[m] = |(pos_m & values) | |(neg_m & ~values); out = &clause. Both are combinational,
//   so mask changes take effect immediately.
// - Clause edge cases:
//   - Empty clause (no literals) is always 0.
//   - A clause with pos and neg set for the same variable is always 1.
// - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps 32'h8020_0003).
//   - Seed 32'hACE1_0001 on reset; advances every cycle, including when out=1.
//   - Never 0.
// - Target clause: the lowest-index m with clause[m]=0.
// - Variable choice:
//   - vars = pos_m|neg_m of the target clause; start index s = lfsr[15:0] % N.
//   - Chosen variable is the first set bit of vars scanning s, s+1, ..., wrapping N-1 -> 0.
// - flip_mask is 0 when out=1 or when the target clause is empty.
// - Sequential (posedge clk):
//   - out=1: values and counter hold. Satisfied state is sticky until masks change or reset.
//   - out=0, counter==FLIPS-1: values <= lfsr[N-1:0] (restart); counter <= 0.
//   - otherwise: values <= values ^ flip_mask; counter <= counter+1.
// - Counter width is $clog2(FLIPS). It wraps only via the restart branch.
// - Reset (async, any time): values=0, counter=0, lfsr=seed. Outputs are therefore defined
//   immediately: flip_mask and out follow from values=0.
// - A mid-run reset replays an identical search sequence for identical masks.
// STRUCTURE
// - Package sat_pla_pkg holds:
//   - LFSR_TAPS, LFSR_SEED constants.
//   - Function first_set_from(vars, s, N) returning a one-hot result.
// - Sub-module sat_lfsr32 (clk, reset, rand[31:0]).
// - Clause evaluation, selection and the control registers live in sat_pla_solver.
// TESTING
// - N=3,M=4: every clause contains ~x0 -> after reset out=1, flip_mask=0, values=0 held 20 cycles.
// - N=10,M=10, clause m = (x_m) -> each cycle exactly one 0-bit of values set.
//   - out=1 with values=10'h3FF within 10 flips (no restart needed at FLIPS=16).
// - N=3: (x0)&(~x0) -> out never 1.
//   - values reloads from lfsr[2:0] every FLIPS cycles; flip_mask always 3'b001.
// - Clause 0 empty (masks 0) -> out=0 and flip_mask=0 forever; restarts still occur.
// - Assert reset mid-search at cycle 7 -> values=0 asynchronously.
//   - Subsequent values/flip_mask trace equals the trace from the first reset.
// - LFSR: compare 1000 cycles against a reference model; the register never reads 0.

Source files
------------

// File: rtl/sat_pla_pkg.sv
// Shared constants and helpers for the PLA-style 3SAT search engine.
package sat_pla_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // One-hot of the first set bit of vars scanning s, s+1, ... and wrapping at n-1 -> 0.
  function automatic logic [31:0] first_set_from(input logic [31:0] vars,
                                                 input int unsigned s,
                                                 input int unsigned n);
    logic [31:0] hit;
    logic        found;
    int unsigned idx;
    hit   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      idx = s + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && vars[idx[4:0]]) begin
        hit[idx[4:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/sat_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1); the nonzero seed keeps it out of the all-zero lockup.
module sat_lfsr32
  import sat_pla_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rand_word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rand_word <= LFSR_SEED;
    else       rand_word <= {1'b0, rand_word[31:1]} ^ (rand_word[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/sat_pla_solver.sv
// WalkSAT-style search: evaluates a CNF formula on the current assignment and flips one
// variable of the first failing clause per cycle, restarting randomly every FLIPS cycles.
module sat_pla_solver
  import sat_pla_pkg::*;
#(
  parameter int N     = 3,
  parameter int M     = 4,
  parameter int FLIPS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M*N-1:0] pos_mask,
  input  logic [M*N-1:0] neg_mask,
  output logic [N-1:0]   values,
  output logic [N-1:0]   flip_mask,
  output logic           out
);

  localparam int CW = $clog2(FLIPS);

  logic [31:0]   lfsr_word;
  logic [CW-1:0] count;
  logic [M-1:0]  clause;
  logic [N-1:0]  target_vars;
  logic          target_found;
  logic [15:0]   start;
  logic [31:0]   pick;
  logic          unused_bits;

  sat_lfsr32 u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .rand_word (lfsr_word)
  );

  // An empty clause has no literal to satisfy it, so it naturally evaluates to 0.
  always_comb begin
    clause = '0;
    for (int m = 0; m < M; m++) begin
      clause[m] = (|(pos_mask[m*N +: N] & values)) | (|(neg_mask[m*N +: N] & ~values));
    end
  end

  assign out = &clause;

  always_comb begin
    target_vars  = '0;
    target_found = 1'b0;
    for (int m = 0; m < M; m++) begin
      if (!target_found && !clause[m]) begin
        target_vars  = pos_mask[m*N +: N] | neg_mask[m*N +: N];
        target_found = 1'b1;
      end
    end
  end

  assign start     = 16'(lfsr_word[15:0] % 16'(N));
  assign pick      = first_set_from(32'(target_vars), 32'(start), 32'(N));
  assign flip_mask = out ? '0 : pick[N-1:0];

  assign unused_bits = ^{lfsr_word[31:16], pick};

  // A satisfied assignment is held; the counter only wraps through the restart branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      values <= '0;
      count  <= '0;
    end else if (!out) begin
      if (count == CW'(FLIPS - 1)) begin
        values <= lfsr_word[N-1:0];
        count  <= '0;
      end else begin
        values <= values ^ flip_mask;
        count  <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sat_pla_solver.sv
// Directed bench for sat_pla_solver: two instances (N=3 and N=10) checked against hand-derived vectors.
module tb_sat_pla_solver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] pos_a, neg_a;
  logic [2:0]  values_a, flip_a;
  logic        out_a;
  logic [99:0] pos_b, neg_b;
  logic [9:0]  values_b, flip_b;
  logic        out_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] lfsr_m;

  sat_pla_solver #(.N(3), .M(4), .FLIPS(8)) dut_a (
    .clk(clk), .reset(reset), .pos_mask(pos_a), .neg_mask(neg_a),
    .values(values_a), .flip_mask(flip_a), .out(out_a)
  );

  sat_pla_solver #(.N(10), .M(10), .FLIPS(16)) dut_b (
    .clk(clk), .reset(reset), .pos_mask(pos_b), .neg_mask(neg_b),
    .values(values_b), .flip_mask(flip_b), .out(out_b)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
  endfunction

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    lfsr_m = 32'hACE1_0001;
  endtask

  // Every clause contains ~x0, so the all-zero reset assignment satisfies the formula.
  task automatic test_reset;
    pos_a = 12'h000;
    neg_a = 12'h249;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (values_a !== 3'b000) begin bad++; $display("FAIL reset_values got=%b exp=000", values_a); end
    total++; if (out_a !== 1'b1) begin bad++; $display("FAIL reset_out got=%b exp=1", out_a); end
    total++; if (flip_a !== 3'b000) begin bad++; $display("FAIL reset_flip got=%b exp=000", flip_a); end
    total++; if (dut_a.lfsr_word !== 32'hACE1_0001) begin bad++; $display("FAIL reset_lfsr got=%h exp=ace10001", dut_a.lfsr_word); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sticky;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++; if (values_a !== 3'b000 || out_a !== 1'b1 || flip_a !== 3'b000) begin
        bad++; $display("FAIL sticky k=%0d got v=%b o=%b f=%b exp v=000 o=1 f=000", k, values_a, out_a, flip_a);
      end
    end
  endtask

  // Masks act combinationally: tautological clauses and empty clauses show up without a clock edge.
  task automatic test_clause_edges;
    do_reset();
    pos_a = 12'h249; neg_a = 12'h249; #1;
    total++; if (out_a !== 1'b1) begin bad++; $display("FAIL taut_x0 got=%b exp=1", out_a); end
    pos_a = 12'h492; neg_a = 12'h492; #1;
    total++; if (out_a !== 1'b1) begin bad++; $display("FAIL taut_x1 got=%b exp=1", out_a); end
    total++; if (flip_a !== 3'b000) begin bad++; $display("FAIL taut_flip got=%b exp=000", flip_a); end
    pos_a = 12'h000; neg_a = 12'h000; #1;
    total++; if (out_a !== 1'b0) begin bad++; $display("FAIL empty_out got=%b exp=0", out_a); end
    pos_a = 12'h492; neg_a = 12'h000; #1;
    total++; if (flip_a !== 3'b010) begin bad++; $display("FAIL single_x1_flip got=%b exp=010", flip_a); end
  endtask

  // (x0)&(~x0)&(x0)&(~x0): x0 toggles every cycle, reload from lfsr[2:0] every 8th edge.
  task automatic test_contradiction;
    logic [2:0] v;
    int c;
    pos_a = 12'h041; neg_a = 12'h208;
    do_reset();
    v = 3'b000; c = 0;
    for (int k = 0; k < 40; k++) begin
      total++; if (values_a !== v) begin bad++; $display("FAIL contra_values k=%0d got=%b exp=%b", k, values_a, v); end
      total++; if (flip_a !== 3'b001 || out_a !== 1'b0) begin
        bad++; $display("FAIL contra_flip k=%0d got f=%b o=%b exp f=001 o=0", k, flip_a, out_a);
      end
      if (c == 7) begin v = lfsr_m[2:0]; c = 0; end
      else begin v = v ^ 3'b001; c++; end
      lfsr_m = lfsr_next(lfsr_m);
      @(negedge clk);
    end
  endtask

  task automatic test_empty_clause;
    logic [2:0] v;
    int c;
    pos_a = 12'h000; neg_a = 12'h000;
    do_reset();
    v = 3'b000; c = 0;
    for (int k = 0; k < 40; k++) begin
      total++; if (values_a !== v) begin bad++; $display("FAIL empty_values k=%0d got=%b exp=%b", k, values_a, v); end
      total++; if (flip_a !== 3'b000 || out_a !== 1'b0) begin
        bad++; $display("FAIL empty_flip k=%0d got f=%b o=%b exp f=000 o=0", k, flip_a, out_a);
      end
      if (c == 7) begin v = lfsr_m[2:0]; c = 0; end
      else c++;
      lfsr_m = lfsr_next(lfsr_m);
      @(negedge clk);
    end
  endtask

  // Reset asserted mid-cycle at cycle 7 must clear values at once and replay the same search.
  task automatic test_mid_reset;
    logic [2:0] v;
    int c;
    pos_a = 12'h041; neg_a = 12'h208;
    do_reset();
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (values_a !== 3'b000) begin bad++; $display("FAIL midrst_values got=%b exp=000", values_a); end
    total++; if (flip_a !== 3'b001) begin bad++; $display("FAIL midrst_flip got=%b exp=001", flip_a); end
    @(negedge clk);
    reset  = 1'b0;
    lfsr_m = 32'hACE1_0001;
    v = 3'b000; c = 0;
    for (int k = 0; k < 20; k++) begin
      total++; if (values_a !== v || flip_a !== 3'b001) begin
        bad++; $display("FAIL midrst_trace k=%0d got v=%b f=%b exp v=%b f=001", k, values_a, flip_a, v);
      end
      if (c == 7) begin v = lfsr_m[2:0]; c = 0; end
      else begin v = v ^ 3'b001; c++; end
      lfsr_m = lfsr_next(lfsr_m);
      @(negedge clk);
    end
  endtask

  // Clause m = (x_m): the lowest clear bit is set each cycle until all ten are 1.
  task automatic test_walk;
    logic [9:0] v;
    pos_b = '0;
    neg_b = '0;
    for (int m = 0; m < 10; m++) pos_b[m*10 + m] = 1'b1;
    do_reset();
    v = 10'h000;
    for (int k = 0; k < 10; k++) begin
      total++; if (values_b !== v) begin bad++; $display("FAIL walk_values k=%0d got=%h exp=%h", k, values_b, v); end
      total++; if (flip_b !== (10'h001 << k) || out_b !== 1'b0) begin
        bad++; $display("FAIL walk_flip k=%0d got f=%h o=%b exp f=%h o=0", k, flip_b, out_b, 10'h001 << k);
      end
      v = v | (10'h001 << k);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      total++; if (values_b !== 10'h3FF || out_b !== 1'b1 || flip_b !== 10'h000) begin
        bad++; $display("FAIL walk_done k=%0d got v=%h o=%b f=%h exp v=3ff o=1 f=000", k, values_b, out_b, flip_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lfsr;
    do_reset();
    @(negedge clk);
    total++; if (dut_a.lfsr_word !== 32'hD650_8003) begin bad++; $display("FAIL lfsr_step1 got=%h exp=d6508003", dut_a.lfsr_word); end
    lfsr_m = lfsr_next(lfsr_m);
    for (int k = 0; k < 1000; k++) begin
      total++; if (dut_a.lfsr_word !== lfsr_m || dut_a.lfsr_word === 32'h0) begin
        bad++; $display("FAIL lfsr_seq k=%0d got=%h exp=%h", k, dut_a.lfsr_word, lfsr_m);
      end
      lfsr_m = lfsr_next(lfsr_m);
      @(negedge clk);
    end
  endtask

  initial begin
    pos_a = '0; neg_a = '0;
    pos_b = '0; neg_b = '0;
    lfsr_m = 32'hACE1_0001;
    test_reset();
    test_sticky();
    test_clause_edges();
    test_contradiction();
    test_empty_clause();
    test_mid_reset();
    test_walk();
    test_lfsr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
